// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC processing element.
// Launch state, vector-length width and saturating narrow.
package mac_pkg;

    localparam string DBG_PLUSARG = "MAC_PE_DEBUG";

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mac_state_t;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } narrow_t;

    function automatic int len_w(int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Clamp a signed value into a width-bit signed range.
    function automatic narrow_t sat_narrow(logic signed [63:0] value, int width);
        narrow_t r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.value = value;
        r.sat   = 1'b0;
        if (value > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (value < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Fixed-point signed multiplier with a MULT_DELAY stage pipeline.
// Each stage carries the product and its valid/last tags.
module mac_mult_pipe #(
    parameter int INPUT_WIDTH = 16,
    parameter int FRAC_WIDTH  = 15,
    parameter int ACC_WIDTH   = 32,
    parameter int MULT_DELAY  = 3
) (
    input  logic                        clk,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic signed [INPUT_WIDTH-1:0] a,
    input  logic signed [INPUT_WIDTH-1:0] b,
    output logic                        out_valid,
    output logic                        out_last,
    output logic signed [ACC_WIDTH-1:0] out_p,
    output logic                        any_valid
);

    localparam int PW = 2 * INPUT_WIDTH;

    logic signed [PW-1:0]        prod_full;
    logic signed [PW-1:0]        prod_sh;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    logic [MULT_DELAY-1:0]       v_q;
    logic [MULT_DELAY-1:0]       l_q;
    logic signed [ACC_WIDTH-1:0] p_q [MULT_DELAY];

    assign prod_full = a * b;
    assign prod_sh   = prod_full >>> FRAC_WIDTH;
    assign prod_ext  = ACC_WIDTH'(prod_sh);

    // Valid/last tags shift down the pipe; flush drops them.
    always_ff @(posedge clk) begin
        if (flush) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            v_q[0] <= in_valid;
            l_q[0] <= in_last;
            for (int i = 1; i < MULT_DELAY; i++) begin
                v_q[i] <= v_q[i-1];
                l_q[i] <= l_q[i-1];
            end
        end
    end

    // Product data follows the tags; qualified by valid only.
    always_ff @(posedge clk) begin
        p_q[0] <= prod_ext;
        for (int i = 1; i < MULT_DELAY; i++) begin
            p_q[i] <= p_q[i-1];
        end
    end

    assign out_valid = v_q[MULT_DELAY-1];
    assign out_last  = l_q[MULT_DELAY-1];
    assign out_p     = p_q[MULT_DELAY-1];
    assign any_valid = |v_q;

endmodule

// File: rtl/mac_pe_dbuf.sv
// Output-stationary systolic MAC PE with runtime length,
// saturating accumulate and a double-buffered result.
module mac_pe_dbuf
    import mac_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int FRAC_WIDTH  = 15,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int MAX_LEN     = 64,
    parameter int MULT_DELAY  = 3,
    parameter int SAT_EN      = 1,
    parameter int MAC_ROW     = 0,
    parameter int MAC_COL     = 0,
    localparam int LEN_W      = len_w(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [LEN_W-1:0]       vec_len,
    input  logic [INPUT_WIDTH-1:0] a_in,
    input  logic                   a_valid_in,
    input  logic [INPUT_WIDTH-1:0] b_in,
    input  logic                   b_valid_in,
    output logic [INPUT_WIDTH-1:0] a_out,
    output logic                   a_valid_out,
    output logic [INPUT_WIDTH-1:0] b_out,
    output logic                   b_valid_out,
    output logic [OUT_WIDTH-1:0]   res_data,
    output logic                   res_sat,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   overrun,
    output logic                   busy
);

    if (MULT_DELAY < 1 || ACC_WIDTH < INPUT_WIDTH + 1 ||
        OUT_WIDTH > ACC_WIDTH || ACC_WIDTH > 64 ||
        MAC_ROW < 0 || MAC_COL < 0) begin : g_bad_cfg
        $error("mac_pe_dbuf: illegal parameter set");
    end

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    logic                        flush;
    logic                        launch;
    mac_state_t                  state;
    mac_state_t                  state_nxt;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            cnt_q;
    logic [LEN_W-1:0]            launch_len;
    logic                        is_last;

    logic                        mp_valid;
    logic                        mp_last;
    logic signed [ACC_WIDTH-1:0] mp_p;
    logic                        mp_busy;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        sat_acc_q;
    logic signed [ACC_WIDTH:0]   sum_w;
    logic signed [ACC_WIDTH-1:0] s;
    logic                        acc_clamp;
    narrow_t                     nr;

    assign flush  = rst | clear;
    assign launch = a_valid_in & b_valid_in;

    // Launch state register.
    always_ff @(posedge clk) begin
        if (flush) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: leave IDLE on a non-last launch, return on last.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (launch && !is_last) state_nxt = ST_RUN;
            ST_RUN:  if (is_last)            state_nxt = ST_IDLE;
        endcase
    end

    // Effective length of a new vector and last-launch tag.
    always_comb begin
        launch_len = vec_len;
        if (vec_len == '0)       launch_len = ONE_L;
        else if (vec_len > MAX_L) launch_len = MAX_L;
        is_last = 1'b0;
        unique case (state)
            ST_IDLE: is_last = launch && (launch_len == ONE_L);
            ST_RUN:  is_last = launch && (cnt_q + ONE_L == len_q);
        endcase
    end

    // Length latch and launch counter.
    always_ff @(posedge clk) begin
        if (flush) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (launch) begin
            if (state == ST_IDLE) begin
                len_q <= launch_len;
                cnt_q <= ONE_L;
            end else begin
                cnt_q <= cnt_q + ONE_L;
            end
        end
    end

    mac_mult_pipe #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .FRAC_WIDTH  (FRAC_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .MULT_DELAY  (MULT_DELAY)
    ) u_mult (
        .clk       (clk),
        .flush     (flush),
        .in_valid  (launch),
        .in_last   (is_last),
        .a         (a_in),
        .b         (b_in),
        .out_valid (mp_valid),
        .out_last  (mp_last),
        .out_p     (mp_p),
        .any_valid (mp_busy)
    );

    // Accumulate with optional clamp, then narrow to the output width.
    always_comb begin
        sum_w = {acc_q[ACC_WIDTH-1], acc_q} + {mp_p[ACC_WIDTH-1], mp_p};
        acc_clamp = (SAT_EN != 0) && (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]);
        s = sum_w[ACC_WIDTH-1:0];
        if (acc_clamp) begin
            if (sum_w[ACC_WIDTH]) s = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            else                  s = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        nr = sat_narrow(64'(s), OUT_WIDTH);
    end

    // Running sum; cleared when the last product retires.
    always_ff @(posedge clk) begin
        if (flush) begin
            acc_q     <= '0;
            sat_acc_q <= 1'b0;
        end else if (mp_valid) begin
            if (mp_last) begin
                acc_q     <= '0;
                sat_acc_q <= 1'b0;
            end else begin
                acc_q     <= s;
                sat_acc_q <= sat_acc_q | acc_clamp;
            end
        end
    end

    // Result buffer with valid/ready drain and sticky overrun.
    always_ff @(posedge clk) begin
        if (flush) begin
            res_data  <= '0;
            res_sat   <= 1'b0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (mp_valid && mp_last) begin
            res_data  <= OUT_WIDTH'(nr.value);
            res_sat   <= sat_acc_q | acc_clamp | nr.sat;
            res_valid <= 1'b1;
            if (res_valid && !res_ready) overrun <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Operand forwarding east/south; data holds when not valid.
    always_ff @(posedge clk) begin
        if (flush) begin
            a_out       <= '0;
            b_out       <= '0;
            a_valid_out <= 1'b0;
            b_valid_out <= 1'b0;
        end else begin
            if (a_valid_in) a_out <= a_in;
            if (b_valid_in) b_out <= b_in;
            a_valid_out <= a_valid_in;
            b_valid_out <= b_valid_in;
        end
    end

    assign busy = (state == ST_RUN) | mp_busy;

endmodule

// File: tb/tb_mac_pe_dbuf.sv
// Bench for mac_pe_dbuf: directed spec scenarios then random
// traffic, all checked against a vector-level reference model.
module tb_mac_pe_dbuf;

    localparam int LW = 7;
    localparam int MD = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [LW-1:0] vec_len = '0;
    logic [15:0]   a_in = '0;
    logic [15:0]   b_in = '0;
    logic          a_valid_in = 1'b0;
    logic          b_valid_in = 1'b0;
    logic [15:0]   a_out;
    logic [15:0]   b_out;
    logic          a_valid_out;
    logic          b_valid_out;
    logic [15:0]   res_data;
    logic          res_sat;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          overrun;
    logic          busy;

    mac_pe_dbuf dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .vec_len     (vec_len),
        .a_in        (a_in),
        .a_valid_in  (a_valid_in),
        .b_in        (b_in),
        .b_valid_in  (b_valid_in),
        .a_out       (a_out),
        .a_valid_out (a_valid_out),
        .b_out       (b_out),
        .b_valid_out (b_valid_out),
        .res_data    (res_data),
        .res_sat     (res_sat),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        sat;
    } res_t;

    res_t        pend[$];
    int          edge_n = 0;
    int          last_launch = 0;
    bit          have_launch = 0;
    longint      m_acc = 0;
    bit          m_sf = 0;
    int          m_idx = 0;
    int          m_len = 1;
    logic        m_rv = 0;
    logic        m_ov = 0;
    logic        m_rs = 0;
    logic [15:0] m_rd = '0;
    logic [15:0] m_aout = '0;
    logic [15:0] m_bout = '0;
    logic        m_avo = 0;
    logic        m_bvo = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        have_launch = 0;
        m_acc = 0; m_sf = 0; m_idx = 0;
        m_rv = 0; m_ov = 0; m_rs = 0; m_rd = '0;
        m_aout = '0; m_bout = '0; m_avo = 0; m_bvo = 0;
    endtask

    // One launch of the dot product, Q1.15 arithmetic.
    task automatic model_launch(logic [15:0] a, logic [15:0] b,
                                logic [LW-1:0] vl);
        longint p, s, n;
        bit cl, nc;
        res_t r;
        if (m_idx == 0) begin
            m_len = (vl == 0) ? 1 : ((vl > 64) ? 64 : int'(vl));
            m_acc = 0;
            m_sf  = 0;
        end
        p = (longint'($signed(a)) * longint'($signed(b))) >>> 15;
        s = m_acc + p;
        cl = 0;
        if (s > 64'sd2147483647) begin s = 64'sd2147483647; cl = 1; end
        else if (s < -64'sd2147483648) begin s = -64'sd2147483648; cl = 1; end
        m_idx++;
        have_launch = 1;
        last_launch = edge_n;
        if (m_idx == m_len) begin
            n = s; nc = 0;
            if (n > 32767) begin n = 32767; nc = 1; end
            else if (n < -32768) begin n = -32768; nc = 1; end
            r.due  = edge_n + MD;
            r.data = 16'(n);
            r.sat  = m_sf | cl | nc;
            pend.push_back(r);
            m_idx = 0;
        end else begin
            m_acc = s;
            m_sf  = m_sf | cl;
        end
    endtask

    // Advance one clock, update the model, check every output.
    task automatic tick();
        logic la, lr, lrst, av, bv;
        logic [15:0] ad, bd;
        logic [LW-1:0] vl;
        res_t r;
        la = a_valid_in & b_valid_in;
        av = a_valid_in; bv = b_valid_in;
        ad = a_in; bd = b_in; vl = vec_len;
        lr = res_ready; lrst = rst | clear;
        @(posedge clk);
        edge_n++;
        if (lrst) begin
            model_reset();
        end else begin
            if (la) model_launch(ad, bd, vl);
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                r = pend.pop_front();
                if (m_rv && !lr) m_ov = 1;
                m_rv = 1; m_rd = r.data; m_rs = r.sat;
            end else if (m_rv && lr) begin
                m_rv = 0;
            end
            if (av) m_aout = ad;
            if (bv) m_bout = bd;
            m_avo = av; m_bvo = bv;
        end
        #1;
        chk("res_valid", res_valid, m_rv);
        chk("overrun", overrun, m_ov);
        chk("busy", busy,
            (m_idx != 0) || (have_launch && edge_n - last_launch < MD));
        chk("a_out", a_out, m_aout);
        chk("b_out", b_out, m_bout);
        chk("a_valid_out", a_valid_out, m_avo);
        chk("b_valid_out", b_valid_out, m_bvo);
        if (m_rv) begin
            chk("res_data", res_data, m_rd);
            chk("res_sat", res_sat, m_rs);
        end
    endtask

    task automatic step(bit av, bit bv, logic [15:0] a, logic [15:0] b);
        a_valid_in = av; b_valid_in = bv;
        a_in = a; b_in = b;
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_res(string tag, int max, output int n);
        n = 0;
        a_valid_in = 0; b_valid_in = 0;
        do begin
            tick();
            n++;
        end while (!res_valid && n < max);
        chk({tag, "_seen"}, res_valid, 1);
    endtask

    task automatic expect_res(string tag, logic [15:0] d, logic s);
        chk({tag, "_data"}, res_data, d);
        chk({tag, "_sat"}, res_sat, s);
    endtask

    int lat;

    initial begin
        // Reset state.
        tick();
        tick();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        res_ready = 1;

        // Basic: 4 x (0.5 * 0.25) = 0.5.
        vec_len = 4;
        for (int i = 0; i < 4; i++) step(1, 1, 16384, 8192);
        wait_res("basic", 10, lat);
        chk("basic_latency", lat, MD);
        expect_res("basic", 16384, 0);
        idle(1);

        // Back-to-back length-2 vectors, no gap.
        vec_len = 2;
        step(1, 1, 16384, 16384);
        step(1, 1, 16384, 16384);
        step(1, 1, 8192, 8192);
        step(1, 1, 8192, 8192);
        wait_res("b2b0", 10, lat);
        expect_res("b2b0", 16384, 0);
        wait_res("b2b1", 10, lat);
        expect_res("b2b1", 4096, 0);
        idle(2);

        // Saturation on narrowing, then a clean vector.
        vec_len = 1;
        step(1, 1, 16'h8000, 16'h8000);
        wait_res("sat", 10, lat);
        expect_res("sat", 32767, 1);
        step(1, 1, 8192, 8192);
        wait_res("nosat", 10, lat);
        expect_res("nosat", 2048, 0);
        idle(2);

        // Zero length behaves as length 1.
        vec_len = 0;
        step(1, 1, 8192, 16384);
        wait_res("len0", 10, lat);
        chk("len0_latency", lat, MD);
        expect_res("len0", 4096, 0);
        idle(2);

        // Overrun: consumer stalled, two results.
        res_ready = 0;
        vec_len = 1;
        step(1, 1, 16384, 16384);
        step(1, 1, 8192, 8192);
        wait_res("ovr_a", 10, lat);
        expect_res("ovr_a", 8192, 0);
        idle(1);
        expect_res("ovr_b", 2048, 0);
        chk("ovr_flag", overrun, 1);
        idle(2);
        chk("ovr_sticky", overrun, 1);
        clear = 1;
        idle(1);
        clear = 0;
        chk("clear_overrun", overrun, 0);
        chk("clear_valid", res_valid, 0);

        // Completion coinciding with accept: no overrun.
        step(1, 1, 16384, 16384);
        step(1, 1, 8192, 8192);
        idle(2);
        chk("coin_first", res_data, 8192);
        res_ready = 1;
        idle(1);
        expect_res("coin", 2048, 0);
        chk("coin_valid", res_valid, 1);
        chk("coin_overrun", overrun, 0);
        idle(2);

        // Gaps and single-sided valids inside a vector.
        vec_len = 3;
        step(1, 1, 16384, 8192);
        step(0, 0, 16'h7777, 16'h6666);
        step(1, 0, 16'h1234, 16'h5555);
        step(1, 1, 16384, 8192);
        step(0, 1, 16'h4321, 16'h2222);
        step(0, 0, 16'hbeef, 16'hcafe);
        chk("fwd_hold_a", a_out, 16384);
        chk("fwd_hold_b", b_out, 16'h2222);
        step(1, 1, 16384, 8192);
        wait_res("gaps", 10, lat);
        expect_res("gaps", 12288, 0);
        idle(2);

        // Reset mid-vector discards the partial sum.
        vec_len = 4;
        step(1, 1, 16384, 16384);
        step(1, 1, 16384, 16384);
        rst = 1;
        idle(1);
        rst = 0;
        idle(6);
        chk("rstmid_novalid", res_valid, 0);
        vec_len = 1;
        step(1, 1, 16384, 16384);
        wait_res("rstmid_fresh", 10, lat);
        expect_res("rstmid_fresh", 8192, 0);
        idle(2);

        // Length above MAX_LEN clamps to 64 launches.
        vec_len = 100;
        for (int i = 0; i < 64; i++) step(1, 1, 16384, 512);
        wait_res("maxlen", 10, lat);
        chk("maxlen_latency", lat, MD);
        expect_res("maxlen", 16384, 0);
        idle(2);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            vec_len = ($urandom_range(0, 15) == 0) ?
                      LW'($urandom_range(60, 127)) :
                      LW'($urandom_range(0, 6));
            res_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 16'($urandom), 16'($urandom));
        end
        clear = 0;
        res_ready = 1;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
